// File: rtl/lsq_alloc_ctrl_pkg.sv
// Shared types and helpers for the LQ/SQ allocation controller.
package lsq_alloc_ctrl_pkg;

    localparam int LQ_SIZE  = 16;
    localparam int SQ_SIZE  = 16;
    localparam int LQ_IDX_W = $clog2(LQ_SIZE);
    localparam int SQ_IDX_W = $clog2(SQ_SIZE);
    localparam int PTR_W    = ((LQ_IDX_W > SQ_IDX_W) ? LQ_IDX_W : SQ_IDX_W) + 1;

    typedef struct packed {
        logic                flipped;
        logic [LQ_IDX_W-1:0] idx;
    } lqPtr_t;

    typedef struct packed {
        logic                sqflipped_unused_guard;
        logic [SQ_IDX_W-1:0] idx;
    } sqPtr_raw_t;

    typedef struct packed {
        logic                flipped;
        logic [SQ_IDX_W-1:0] idx;
    } sqPtr_t;

    // {flip, idx} is a counter modulo 2*size, so plain subtraction gives occupancy.
    function automatic logic [PTR_W-1:0] ptr_distance(input logic [PTR_W-1:0] head,
                                                      input logic [PTR_W-1:0] tail,
                                                      input int size);
        logic [PTR_W-1:0] mask;
        mask = PTR_W'(2 * size - 1);
        return (tail - head) & mask;
    endfunction

endpackage

// File: rtl/lsq_alloc_ctrl_ptr.sv
// Head/tail/free-count tracker for one circular queue (LQ or SQ).
module lsq_ptr_ctrl
    import lsq_alloc_ctrl_pkg::*;
#(
    parameter int SIZE        = 16,
    parameter int DEALLOC_WID = 2,
    parameter int ALLOC_WID   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [$clog2(ALLOC_WID+1)-1:0]   i_alloc_num,
    input  logic [$clog2(DEALLOC_WID+1)-1:0] i_dealloc_num,
    input  logic                             i_squash_vld,
    input  logic [$clog2(SIZE):0]            i_squash_ptr,
    output logic [$clog2(SIZE):0]            o_tail,
    output logic [$clog2(SIZE):0]            o_free_cnt
);

    localparam int PW = $clog2(SIZE) + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW-1:0] free_q, free_d;
    logic [PW-1:0] occ;

    always_comb begin
        head_d = head_q + PW'(i_dealloc_num);
        tail_d = i_squash_vld ? i_squash_ptr : tail_q + PW'(i_alloc_num);
        free_d = PW'(SIZE) - PW'(ptr_distance(PTR_W'(head_d), PTR_W'(tail_d), SIZE));
        occ    = PW'(ptr_distance(PTR_W'(head_q), PTR_W'(tail_q), SIZE));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            free_q <= PW'(SIZE);
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            free_q <= free_d;
        end
    end

    assign o_tail     = tail_q;
    assign o_free_cnt = free_q;

`ifndef SYNTHESIS
    a_dealloc_le_occ: assert property (@(posedge clk) disable iff (rst)
        PW'(i_dealloc_num) <= occ);
    a_squash_in_range: assert property (@(posedge clk) disable iff (rst)
        i_squash_vld |-> PW'(ptr_distance(PTR_W'(head_q), PTR_W'(i_squash_ptr), SIZE)) <= occ);
`endif

endmodule

// File: rtl/lsq_alloc_ctrl.sv
// In-order LQ/SQ allocation: grants a contiguous prefix of dispatch slots and stamps queue pointers.
// Optional stall counters are built when LSQ_ALLOC_PERF_EN is defined.
module lsq_alloc_ctrl
    import lsq_alloc_ctrl_pkg::*;
#(
    parameter int INPUT_NUM      = 4,
    parameter int MAX_LD_PER_CYC = 2,
    parameter int MAX_ST_PER_CYC = 2,
    parameter int DEALLOC_WID    = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  i_squash_vld,
    input  logic [LQ_IDX_W:0]                     i_squash_lq_ptr,
    input  logic [SQ_IDX_W:0]                     i_squash_sq_ptr,
    input  logic [INPUT_NUM-1:0]                  i_req_vld,
    input  logic [INPUT_NUM-1:0]                  i_req_is_ld,
    output logic [INPUT_NUM-1:0]                  o_grant,
    output logic [INPUT_NUM-1:0][LQ_IDX_W:0]      o_lq_ptr,
    output logic [INPUT_NUM-1:0][SQ_IDX_W:0]      o_sq_ptr,
    input  logic [$clog2(DEALLOC_WID+1)-1:0]      i_ld_dealloc_num,
    input  logic [$clog2(DEALLOC_WID+1)-1:0]      i_st_dealloc_num,
    output logic [LQ_IDX_W:0]                     o_lq_free_cnt,
    output logic [SQ_IDX_W:0]                     o_sq_free_cnt
`ifdef LSQ_ALLOC_PERF_EN
    ,
    output logic [31:0]                           o_perf_lq_full_stall,
    output logic [31:0]                           o_perf_sq_full_stall
`endif
);

    localparam int CNT_W = $clog2(INPUT_NUM + 1);
    localparam int LQ_PW = LQ_IDX_W + 1;
    localparam int SQ_PW = SQ_IDX_W + 1;

    lqPtr_t           lq_tail;
    sqPtr_t           sq_tail;
    logic [CNT_W-1:0] ld_gnt_num, st_gnt_num;
`ifdef LSQ_ALLOC_PERF_EN
    logic             lq_stall, sq_stall;
`endif

    // Counts include every valid slot so non-granted slots still show the pointer they would get.
    always_comb begin
        int   ld_n, st_n, ld_g, st_g;
        logic blk, rate_ok, ld_room, st_room;
        ld_n    = 0;
        st_n    = 0;
        ld_g    = 0;
        st_g    = 0;
        rate_ok = 1'b0;
        ld_room = 1'b0;
        st_room = 1'b0;
        blk     = rst | i_squash_vld;
        o_grant = '0;
`ifdef LSQ_ALLOC_PERF_EN
        lq_stall = 1'b0;
        sq_stall = 1'b0;
`endif
        for (int i = 0; i < INPUT_NUM; i++) begin
            o_lq_ptr[i] = lq_tail + LQ_PW'(ld_n);
            o_sq_ptr[i] = sq_tail + SQ_PW'(st_n);
            if (i_req_vld[i]) begin
                if (i_req_is_ld[i]) ld_n++;
                else                st_n++;
            end
            rate_ok = (ld_n <= MAX_LD_PER_CYC) && (st_n <= MAX_ST_PER_CYC);
            ld_room = ld_n <= int'(o_lq_free_cnt);
            st_room = st_n <= int'(o_sq_free_cnt);
            if (!blk && i_req_vld[i]) begin
                if (rate_ok && ld_room && st_room) begin
                    o_grant[i] = 1'b1;
                    if (i_req_is_ld[i]) ld_g++;
                    else                st_g++;
                end
`ifdef LSQ_ALLOC_PERF_EN
                else begin
                    lq_stall = rate_ok && !ld_room && st_room;
                    sq_stall = rate_ok && ld_room && !st_room;
                end
`endif
            end
            if (!o_grant[i]) blk = 1'b1;
        end
        ld_gnt_num = CNT_W'(ld_g);
        st_gnt_num = CNT_W'(st_g);
    end

    lsq_ptr_ctrl #(.SIZE(LQ_SIZE), .DEALLOC_WID(DEALLOC_WID), .ALLOC_WID(INPUT_NUM)) u_lq_ptr (
        .clk           (clk),
        .rst           (rst),
        .i_alloc_num   (ld_gnt_num),
        .i_dealloc_num (i_ld_dealloc_num),
        .i_squash_vld  (i_squash_vld),
        .i_squash_ptr  (i_squash_lq_ptr),
        .o_tail        (lq_tail),
        .o_free_cnt    (o_lq_free_cnt)
    );

    lsq_ptr_ctrl #(.SIZE(SQ_SIZE), .DEALLOC_WID(DEALLOC_WID), .ALLOC_WID(INPUT_NUM)) u_sq_ptr (
        .clk           (clk),
        .rst           (rst),
        .i_alloc_num   (st_gnt_num),
        .i_dealloc_num (i_st_dealloc_num),
        .i_squash_vld  (i_squash_vld),
        .i_squash_ptr  (i_squash_sq_ptr),
        .o_tail        (sq_tail),
        .o_free_cnt    (o_sq_free_cnt)
    );

`ifdef LSQ_ALLOC_PERF_EN
    logic [31:0] lq_stall_cnt_q, lq_stall_cnt_d;
    logic [31:0] sq_stall_cnt_q, sq_stall_cnt_d;

    always_comb begin
        lq_stall_cnt_d = lq_stall_cnt_q;
        sq_stall_cnt_d = sq_stall_cnt_q;
        if (lq_stall && lq_stall_cnt_q != '1) lq_stall_cnt_d = lq_stall_cnt_q + 32'd1;
        if (sq_stall && sq_stall_cnt_q != '1) sq_stall_cnt_d = sq_stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lq_stall_cnt_q <= '0;
            sq_stall_cnt_q <= '0;
        end else begin
            lq_stall_cnt_q <= lq_stall_cnt_d;
            sq_stall_cnt_q <= sq_stall_cnt_d;
        end
    end

    assign o_perf_lq_full_stall = lq_stall_cnt_q;
    assign o_perf_sq_full_stall = sq_stall_cnt_q;
`endif

endmodule

// File: tb/tb_lsq_alloc_ctrl.sv
// Directed self-checking bench for lsq_alloc_ctrl; perf-counter scenario built with LSQ_ALLOC_PERF_EN.
module tb_lsq_alloc_ctrl;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_squash_vld;
    logic [4:0]       i_squash_lq_ptr, i_squash_sq_ptr;
    logic [3:0]       i_req_vld, i_req_is_ld;
    logic [3:0]       o_grant;
    logic [3:0][4:0]  o_lq_ptr, o_sq_ptr;
    logic [1:0]       i_ld_dealloc_num, i_st_dealloc_num;
    logic [4:0]       o_lq_free_cnt, o_sq_free_cnt;
`ifdef LSQ_ALLOC_PERF_EN
    logic [31:0]      o_perf_lq_full_stall, o_perf_sq_full_stall;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lsq_alloc_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .i_squash_vld     (i_squash_vld),
        .i_squash_lq_ptr  (i_squash_lq_ptr),
        .i_squash_sq_ptr  (i_squash_sq_ptr),
        .i_req_vld        (i_req_vld),
        .i_req_is_ld      (i_req_is_ld),
        .o_grant          (o_grant),
        .o_lq_ptr         (o_lq_ptr),
        .o_sq_ptr         (o_sq_ptr),
        .i_ld_dealloc_num (i_ld_dealloc_num),
        .i_st_dealloc_num (i_st_dealloc_num),
        .o_lq_free_cnt    (o_lq_free_cnt),
        .o_sq_free_cnt    (o_sq_free_cnt)
`ifdef LSQ_ALLOC_PERF_EN
        ,
        .o_perf_lq_full_stall (o_perf_lq_full_stall),
        .o_perf_sq_full_stall (o_perf_sq_full_stall)
`endif
    );

    task automatic idle_inputs();
        i_squash_vld = 0; i_squash_lq_ptr = 0; i_squash_sq_ptr = 0;
        i_req_vld = 0; i_req_is_ld = 0; i_ld_dealloc_num = 0; i_st_dealloc_num = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    // Present one cycle of requests/deallocs, then return idle 1 time unit after the edge.
    task automatic run_cycle(input logic [3:0] vld, input logic [3:0] is_ld,
                             input logic [1:0] ld_d, input logic [1:0] st_d);
        i_req_vld = vld; i_req_is_ld = is_ld; i_ld_dealloc_num = ld_d; i_st_dealloc_num = st_d;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; i_req_vld = 4'b1111; i_req_is_ld = 4'b1111;
        @(posedge clk); #1;
        n_chk++; if (o_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", o_grant); end
        @(posedge clk); #1;
        idle_inputs(); rst = 0; #1;
        n_chk++; if (o_lq_free_cnt !== 5'd16) begin n_fail++; $display("FAIL reset_lq_free got %0d want 16", o_lq_free_cnt); end
        n_chk++; if (o_sq_free_cnt !== 5'd16) begin n_fail++; $display("FAIL reset_sq_free got %0d want 16", o_sq_free_cnt); end
        n_chk++; if (o_lq_ptr[0] !== 5'd0 || o_sq_ptr[0] !== 5'd0) begin n_fail++; $display("FAIL reset_tails got %0d/%0d want 0/0", o_lq_ptr[0], o_sq_ptr[0]); end
    endtask

    task automatic test_loads();
        do_reset();
        i_req_vld = 4'b1111; i_req_is_ld = 4'b1111; #1;
        n_chk++; if (o_grant !== 4'b0011) begin n_fail++; $display("FAIL loads_grant got %b want 0011", o_grant); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (o_lq_ptr[i] !== 5'(i)) begin n_fail++; $display("FAIL loads_lq_ptr%0d got %0d want %0d", i, o_lq_ptr[i], i); end
        end
        @(posedge clk); #1; idle_inputs(); #1;
        n_chk++; if (o_lq_ptr[0] !== 5'd2) begin n_fail++; $display("FAIL loads_tail got %0d want 2", o_lq_ptr[0]); end
        n_chk++; if (o_lq_free_cnt !== 5'd14) begin n_fail++; $display("FAIL loads_free got %0d want 14", o_lq_free_cnt); end
    endtask

    task automatic test_mixed();
        do_reset();
        i_req_vld = 4'b1111; i_req_is_ld = 4'b0101; #1;
        n_chk++; if (o_grant !== 4'b1111) begin n_fail++; $display("FAIL mixed_grant got %b want 1111", o_grant); end
        n_chk++; if (o_lq_ptr[2] !== 5'd1) begin n_fail++; $display("FAIL mixed_lq_ptr2 got %0d want 1", o_lq_ptr[2]); end
        n_chk++; if (o_sq_ptr[3] !== 5'd1) begin n_fail++; $display("FAIL mixed_sq_ptr3 got %0d want 1", o_sq_ptr[3]); end
        n_chk++; if (o_lq_ptr[1] !== 5'd1) begin n_fail++; $display("FAIL mixed_st_sees_lq got %0d want 1", o_lq_ptr[1]); end
        @(posedge clk); #1; idle_inputs(); #1;
        n_chk++; if (o_lq_ptr[0] !== 5'd2 || o_sq_ptr[0] !== 5'd2) begin n_fail++; $display("FAIL mixed_tails got %0d/%0d want 2/2", o_lq_ptr[0], o_sq_ptr[0]); end
        n_chk++; if (o_lq_free_cnt !== 5'd14 || o_sq_free_cnt !== 5'd14) begin n_fail++; $display("FAIL mixed_free got %0d/%0d want 14/14", o_lq_free_cnt, o_sq_free_cnt); end
    endtask

    task automatic test_lq_full();
        do_reset();
        repeat (7) run_cycle(4'b0011, 4'b0011, 2'd0, 2'd0);
        run_cycle(4'b0001, 4'b0001, 2'd0, 2'd0);
        n_chk++; if (o_lq_free_cnt !== 5'd1) begin n_fail++; $display("FAIL full_free1 got %0d want 1", o_lq_free_cnt); end
        i_req_vld = 4'b0111; i_req_is_ld = 4'b0011; #1;
        n_chk++; if (o_grant !== 4'b0001) begin n_fail++; $display("FAIL full_grant got %b want 0001", o_grant); end
        n_chk++; if (o_lq_ptr[1] !== 5'b10000) begin n_fail++; $display("FAIL full_wrap_ptr got %b want 10000", o_lq_ptr[1]); end
        @(posedge clk); #1; idle_inputs(); #1;
        n_chk++; if (o_lq_free_cnt !== 5'd0) begin n_fail++; $display("FAIL full_free0 got %0d want 0", o_lq_free_cnt); end
        n_chk++; if (o_lq_ptr[0] !== 5'b10000) begin n_fail++; $display("FAIL full_tail got %b want 10000", o_lq_ptr[0]); end
        i_req_vld = 4'b0001; i_req_is_ld = 4'b0001; #1;
        n_chk++; if (o_grant !== 4'b0000) begin n_fail++; $display("FAIL full_ld_blocked got %b want 0000", o_grant); end
        i_req_is_ld = 4'b0000; #1;
        n_chk++; if (o_grant !== 4'b0001) begin n_fail++; $display("FAIL full_st_ok got %b want 0001", o_grant); end
        idle_inputs();
    endtask

    task automatic test_gap();
        do_reset();
        i_req_vld = 4'b0101; i_req_is_ld = 4'b1111; #1;
        n_chk++; if (o_grant !== 4'b0001) begin n_fail++; $display("FAIL gap_grant got %b want 0001", o_grant); end
        idle_inputs();
    endtask

    task automatic test_store_limit();
        do_reset();
        i_req_vld = 4'b1111; i_req_is_ld = 4'b0000; #1;
        n_chk++; if (o_grant !== 4'b0011) begin n_fail++; $display("FAIL st_limit_grant got %b want 0011", o_grant); end
        n_chk++; if (o_sq_ptr[3] !== 5'd3) begin n_fail++; $display("FAIL st_limit_ptr3 got %0d want 3", o_sq_ptr[3]); end
        @(posedge clk); #1; idle_inputs(); #1;
        n_chk++; if (o_sq_free_cnt !== 5'd14) begin n_fail++; $display("FAIL st_free14 got %0d want 14", o_sq_free_cnt); end
        run_cycle(4'b0000, 4'b0000, 2'd0, 2'd2);
        n_chk++; if (o_sq_free_cnt !== 5'd16) begin n_fail++; $display("FAIL st_dealloc_free got %0d want 16", o_sq_free_cnt); end
        n_chk++; if (o_sq_ptr[0] !== 5'd2) begin n_fail++; $display("FAIL st_dealloc_tail got %0d want 2", o_sq_ptr[0]); end
    endtask

    task automatic test_squash();
        do_reset();
        repeat (5) run_cycle(4'b0011, 4'b0011, 2'd0, 2'd0);
        repeat (2) run_cycle(4'b0000, 4'b0000, 2'd2, 2'd0);
        n_chk++; if (o_lq_free_cnt !== 5'd10) begin n_fail++; $display("FAIL sq_pre_free got %0d want 10", o_lq_free_cnt); end
        i_squash_vld = 1; i_squash_lq_ptr = 5'd6; i_squash_sq_ptr = 5'd0; i_ld_dealloc_num = 2'd2;
        i_req_vld = 4'b1111; i_req_is_ld = 4'b1111; #1;
        n_chk++; if (o_grant !== 4'b0000) begin n_fail++; $display("FAIL squash_grant got %b want 0000", o_grant); end
        @(posedge clk); #1; idle_inputs(); #1;
        n_chk++; if (o_lq_ptr[0] !== 5'd6) begin n_fail++; $display("FAIL squash_tail got %0d want 6", o_lq_ptr[0]); end
        n_chk++; if (o_lq_free_cnt !== 5'd16) begin n_fail++; $display("FAIL squash_free got %0d want 16", o_lq_free_cnt); end
    endtask

`ifdef LSQ_ALLOC_PERF_EN
    task automatic test_perf();
        do_reset();
        n_chk++; if (o_perf_sq_full_stall !== 32'd0) begin n_fail++; $display("FAIL perf_reset got %0d want 0", o_perf_sq_full_stall); end
        repeat (8) run_cycle(4'b0011, 4'b0000, 2'd0, 2'd0);
        repeat (5) run_cycle(4'b0001, 4'b0000, 2'd0, 2'd0);
        n_chk++; if (o_perf_sq_full_stall !== 32'd5) begin n_fail++; $display("FAIL perf_sq got %0d want 5", o_perf_sq_full_stall); end
        n_chk++; if (o_perf_lq_full_stall !== 32'd0) begin n_fail++; $display("FAIL perf_lq got %0d want 0", o_perf_lq_full_stall); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_loads();
        test_mixed();
        test_lq_full();
        test_gap();
        test_store_limit();
        test_squash();
`ifdef LSQ_ALLOC_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
